// File: rtl/if_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : if_pkg                                                            |
// | Brief  : Shared widths, fetch entry type and counter sizing helper.        |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package if_pkg;

  localparam int FETCH_ADDR_W = 64;
  localparam int FETCH_INST_W = 32;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] addr;
    logic [FETCH_INST_W-1:0] data;
  } fetch_entry_t;

  // Occupancy counters must represent 0..n inclusive.
  function automatic int cntW(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_fetch_buffer_sync_fifo.sv
// +----------------------------------------------------------------------------+
// | Module : sync_fifo                                                         |
// | Brief  : Single-clock FIFO with occupancy count and synchronous clear.     |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module sync_fifo
  import if_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         popData,
  output logic [cntW(DEPTH)-1:0]   count
);

  localparam int CNT_W = cntW(DEPTH);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_doPush;
  logic             w_doPop;

  // A full FIFO can still take a write when the head leaves in the same cycle.
  assign w_doPop  = pop & (r_count != '0);
  assign w_doPush = push & ((r_count != FULL_CNT) | w_doPop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (clear) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_mem[r_wrPtr] <= pushData;
        r_wrPtr        <= (r_wrPtr == LAST_PTR) ? '0 : r_wrPtr + PTR_W'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= (r_rdPtr == LAST_PTR) ? '0 : r_rdPtr + PTR_W'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign popData = r_mem[r_rdPtr];
  assign count   = r_count;

endmodule

`default_nettype wire

// File: rtl/if_fetch_buffer.sv
// +----------------------------------------------------------------------------+
// | Module : if_fetch_buffer                                                   |
// | Brief  : Fetch stage: credit-limited imem requests, in-order pairing of    |
// |          returned instructions with addresses, output FIFO, flush drop.    |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module if_fetch_buffer
  import if_pkg::*;
#(
  parameter int ADDR_W  = FETCH_ADDR_W,
  parameter int INST_W  = FETCH_INST_W,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              pc_valid,
  output logic              pc_ready,
  input  logic              flush,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_ready
);

  localparam int IF_CW  = cntW(MAX_OUT);
  localparam int OUT_CW = cntW(DEPTH);
  localparam int SUM_W  = ((IF_CW > OUT_CW) ? IF_CW : OUT_CW) + 1;
  localparam int ENT_W  = ADDR_W + INST_W;

  logic [IF_CW-1:0]  w_inflight;
  logic [OUT_CW-1:0] w_outCount;
  logic [SUM_W-1:0]  w_occupancy;
  logic [ADDR_W-1:0] w_headAddr;
  logic [ENT_W-1:0]  w_outHead;
  logic              w_canIssue;
  logic              w_fire;
  logic              w_rspAccept;
  logic              w_outPush;
  logic [IF_CW-1:0]  r_dropCnt;

  // Every slot already promised (in flight) or occupied counts against DEPTH,
  // so a returning response always finds room in the output FIFO.
  assign w_occupancy = SUM_W'(w_inflight) + SUM_W'(w_outCount);
  assign w_canIssue  = rst_n & ~flush
                     & (w_occupancy < SUM_W'(DEPTH))
                     & (w_inflight < IF_CW'(MAX_OUT));

  assign imem_req_valid = pc_valid & w_canIssue;
  assign imem_req_addr  = pc_addr;
  assign pc_ready       = imem_req_ready & w_canIssue;
  assign w_fire         = imem_req_valid & imem_req_ready;

  // Responses with nothing outstanding (e.g. stragglers after reset) are ignored.
  assign w_rspAccept = imem_rsp_valid & (w_inflight != '0);
  assign w_outPush   = w_rspAccept & (r_dropCnt == '0) & ~flush;

  sync_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (MAX_OUT)
  ) u_addrFifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (1'b0),
    .push     (w_fire),
    .pushData (pc_addr),
    .pop      (w_rspAccept),
    .popData  (w_headAddr),
    .count    (w_inflight)
  );

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_outFifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (flush),
    .push     (w_outPush),
    .pushData ({w_headAddr, imem_rsp_data}),
    .pop      (inst_ready),
    .popData  (w_outHead),
    .count    (w_outCount)
  );

  // On redirect, everything still outstanding after this cycle's response is stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dropCnt <= '0;
    end else if (flush) begin
      r_dropCnt <= w_inflight - IF_CW'(w_rspAccept);
    end else if (w_rspAccept && (r_dropCnt != '0)) begin
      r_dropCnt <= r_dropCnt - IF_CW'(1);
    end
  end

  assign inst_valid = (w_outCount != '0);
  assign inst_addr  = w_outHead[ENT_W-1 -: ADDR_W];
  assign inst_data  = w_outHead[INST_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_buffer.sv
// Self-checking bench for if_fetch_buffer: directed vector table, corner-case
// sequences and a randomized run against a queue-based reference model.
`default_nettype none

module tb_if_fetch_buffer;
  import if_pkg::*;

  localparam int AW      = 64;
  localparam int IW      = 32;
  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 4;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] pc_addr;
  logic          pc_valid;
  logic          pc_ready;
  logic          flush;
  logic          imem_req_valid;
  logic [AW-1:0] imem_req_addr;
  logic          imem_req_ready;
  logic          imem_rsp_valid;
  logic [IW-1:0] imem_rsp_data;
  logic          inst_valid;
  logic [IW-1:0] inst_data;
  logic [AW-1:0] inst_addr;
  logic          inst_ready;

  if_fetch_buffer #(
    .ADDR_W (AW), .INST_W (IW), .DEPTH (DEPTH), .MAX_OUT (MAX_OUT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_addr        (pc_addr),
    .pc_valid       (pc_valid),
    .pc_ready       (pc_ready),
    .flush          (flush),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_addr      (inst_addr),
    .inst_ready     (inst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] memData(input logic [AW-1:0] a);
    return 32'hDEAD_0000 ^ a[31:0];
  endfunction

  // Reference model: outstanding addresses, pending drops, decode-visible queue.
  logic [AW-1:0] mFlight[$];
  fetch_entry_t  mOut[$];
  int            mDrop;

  // Memory emulator: accepted requests returned in order once due.
  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } memReq_t;
  memReq_t memQ[$];
  int      cyc;
  int      memJit;

  bit            lastFire;
  logic          obsPcReady;
  logic          obsInstValid;
  logic [AW-1:0] gotAddrs[$];

  task automatic modelClear();
    mFlight.delete();
    mOut.delete();
    mDrop = 0;
  endtask

  task automatic memRsp(output bit rv, output logic [IW-1:0] rd);
    rv = 1'b0;
    rd = $urandom;
    if (memQ.size() != 0 && memQ[0].due <= cyc) begin
      rv = 1'b1;
      rd = memData(memQ[0].addr);
      void'(memQ.pop_front());
    end
  endtask

  task automatic cycle(input bit pv, input logic [AW-1:0] pa, input bit rr,
                       input bit rv, input logic [IW-1:0] rd, input bit ir, input bit fl);
    bit            canIssue;
    bit            rsp;
    bit            fire;
    logic [AW-1:0] a;
    pc_valid = pv; pc_addr = pa; imem_req_ready = rr;
    imem_rsp_valid = rv; imem_rsp_data = rd; inst_ready = ir; flush = fl;
    #3;
    canIssue = (mFlight.size() + mOut.size() < DEPTH) && (mFlight.size() < MAX_OUT) && !fl;
    check("pc_ready", pc_ready, rr && canIssue);
    check("req_valid", imem_req_valid, pv && canIssue);
    if (pv && canIssue) check("req_addr", imem_req_addr, pa);
    check("inst_valid", inst_valid, mOut.size() != 0);
    if (mOut.size() != 0) begin
      check("inst_addr", inst_addr, mOut[0].addr);
      check("inst_data", inst_data, mOut[0].data);
    end
    obsPcReady   = pc_ready;
    obsInstValid = inst_valid;
    if (inst_valid && ir && !fl) gotAddrs.push_back(inst_addr);
    @(posedge clk);
    fire = pv && rr && canIssue;
    rsp  = rv && (mFlight.size() != 0);
    if (fl) begin
      mOut.delete();
      if (rsp) void'(mFlight.pop_front());
      mDrop = mFlight.size();
    end else begin
      if (ir && mOut.size() != 0) void'(mOut.pop_front());
      if (rsp) begin
        a = mFlight.pop_front();
        if (mDrop == 0) mOut.push_back('{addr: a, data: rd});
        else mDrop--;
      end
    end
    if (fire) begin
      mFlight.push_back(pa);
      memQ.push_back('{addr: pa, due: cyc + 1 + ((memJit > 0) ? int'($urandom_range(0, memJit)) : 0)});
    end
    lastFire = fire;
    cyc++;
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    pc_valid = 0; pc_addr = '0; imem_req_ready = 0; imem_rsp_valid = 0;
    imem_rsp_data = '0; inst_ready = 0; flush = 0;
    modelClear();
    memQ.delete();
    gotAddrs.delete();
    cyc = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    bit            pv;
    logic [AW-1:0] pa;
    bit            rv;
    logic [IW-1:0] rd;
    bit            expPcReady;
    bit            expReqValid;
    bit            expInstValid;
    logic [AW-1:0] expAddr;
    logic [IW-1:0] expData;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit            rv;
    bit            pv;
    logic [IW-1:0] rd;
    logic [AW-1:0] pc;
    int            acc;
    bit            seen;

    memJit = 0;
    rst_n = 1'b1;
    pc_valid = 1; pc_addr = 64'h40; imem_req_ready = 1; imem_rsp_valid = 0;
    imem_rsp_data = '0; inst_ready = 0; flush = 0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_pc_ready", pc_ready, 0);
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst_addr", inst_addr, 0);
    check("rst_inst_data", inst_data, 0);
    doReset();

    // Streaming with 1-cycle memory, decode always ready.
    vecs[0] = '{1, 64'h0, 0, 32'h0,         1, 1, 0, 64'h0, 32'h0};
    vecs[1] = '{1, 64'h4, 1, 32'hDEAD0000,  1, 1, 0, 64'h0, 32'h0};
    vecs[2] = '{1, 64'h8, 1, 32'hDEAD0004,  1, 1, 1, 64'h0, 32'hDEAD0000};
    vecs[3] = '{1, 64'hC, 1, 32'hDEAD0008,  1, 1, 1, 64'h4, 32'hDEAD0004};
    vecs[4] = '{0, 64'h0, 1, 32'hDEAD000C,  1, 0, 1, 64'h8, 32'hDEAD0008};
    vecs[5] = '{0, 64'h0, 0, 32'h0,         1, 0, 1, 64'hC, 32'hDEAD000C};
    vecs[6] = '{0, 64'h0, 0, 32'h0,         1, 0, 0, 64'h0, 32'h0};
    for (int i = 0; i < 7; i++) begin
      pc_valid = vecs[i].pv; pc_addr = vecs[i].pa; imem_req_ready = 1;
      imem_rsp_valid = vecs[i].rv; imem_rsp_data = vecs[i].rd; inst_ready = 1; flush = 0;
      #3;
      check("vec_pc_ready", pc_ready, vecs[i].expPcReady);
      check("vec_req_valid", imem_req_valid, vecs[i].expReqValid);
      check("vec_inst_valid", inst_valid, vecs[i].expInstValid);
      if (vecs[i].expInstValid) begin
        check("vec_inst_addr", inst_addr, vecs[i].expAddr);
        check("vec_inst_data", inst_data, vecs[i].expData);
      end
      @(posedge clk);
      #1;
    end

    // Full stall: decode blocked, only DEPTH requests accepted.
    doReset();
    pc = 0; acc = 0;
    for (int i = 0; i < 10; i++) begin
      memRsp(rv, rd);
      cycle(1, pc, 1, rv, rd, 0, 0);
      if (lastFire) begin acc++; pc += 4; end
    end
    check("stall_accepted", acc, 4);
    check("stall_pc_ready", obsPcReady, 0);
    cycle(1, pc, 1, 0, 0, 1, 0);
    check("stall_pop_cycle_ready", obsPcReady, 0);
    cycle(1, pc, 1, 0, 0, 0, 0);
    check("stall_after_pop_ready", obsPcReady, 1);
    for (int i = 0; i < 8; i++) begin
      memRsp(rv, rd);
      cycle(0, 0, 1, rv, rd, 1, 0);
    end

    // Memory stall: PC holds 0x8 until memory accepts; issued exactly once.
    doReset();
    pc = 0;
    for (int i = 0; i < 2; i++) begin
      memRsp(rv, rd);
      cycle(1, pc, 1, rv, rd, 1, 0);
      if (lastFire) pc += 4;
    end
    for (int i = 0; i < 3; i++) begin
      memRsp(rv, rd);
      cycle(1, pc, 0, rv, rd, 1, 0);
      check("mstall_pc_ready", obsPcReady, 0);
    end
    memRsp(rv, rd);
    cycle(1, pc, 1, rv, rd, 1, 0);
    check("mstall_release_fire", lastFire, 1);
    if (lastFire) pc += 4;
    memRsp(rv, rd);
    cycle(1, pc, 1, rv, rd, 1, 0);
    for (int i = 0; i < 6; i++) begin
      memRsp(rv, rd);
      cycle(0, 0, 1, rv, rd, 1, 0);
    end
    check("mstall_out_count", gotAddrs.size(), 4);
    for (int i = 0; i < gotAddrs.size() && i < 4; i++)
      check("mstall_out_addr", gotAddrs[i], 64'(4 * i));

    // Flush with 2 in flight and 2 buffered.
    doReset();
    pc = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1, pc, 1, 0, 0, 0, 0);
      if (lastFire) pc += 4;
    end
    for (int i = 0; i < 2; i++) begin
      memRsp(rv, rd);
      cycle(0, 0, 1, rv, rd, 0, 0);
    end
    cycle(1, 64'h100, 1, 0, 0, 0, 1);
    check("flush_no_issue", obsPcReady, 0);
    gotAddrs.delete();
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      memRsp(rv, rd);
      cycle(!seen, 64'h100, 1, rv, rd, 1, 0);
      if (i == 0) check("flush_empty_next", obsInstValid, 0);
      if (lastFire) seen = 1;
    end
    check("flush_out_count", gotAddrs.size(), 1);
    if (gotAddrs.size() != 0) check("flush_new_addr", gotAddrs[0], 64'h100);

    // Flush coinciding with a response.
    doReset();
    pc = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1, pc, 1, 0, 0, 0, 0);
      if (lastFire) pc += 4;
    end
    memRsp(rv, rd);
    cycle(0, 0, 1, rv, rd, 0, 1);
    gotAddrs.delete();
    for (int i = 0; i < 4; i++) begin
      memRsp(rv, rd);
      cycle(0, 0, 1, rv, rd, 1, 0);
      check("flushrsp_no_stale", obsInstValid, 0);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      memRsp(rv, rd);
      cycle(!seen, 64'h200, 1, rv, rd, 1, 0);
      if (lastFire) seen = 1;
    end
    check("flushrsp_out_count", gotAddrs.size(), 1);
    if (gotAddrs.size() != 0) check("flushrsp_new_addr", gotAddrs[0], 64'h200);

    // Async reset with 3 in flight and 1 buffered.
    doReset();
    pc = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1, pc, 1, 0, 0, 0, 0);
      if (lastFire) pc += 4;
    end
    memRsp(rv, rd);
    cycle(0, 0, 1, rv, rd, 0, 0);
    pc_valid = 1;
    rst_n = 1'b0;
    #1;
    check("arst_inst_valid", inst_valid, 0);
    check("arst_inst_addr", inst_addr, 0);
    check("arst_inst_data", inst_data, 0);
    check("arst_pc_ready", pc_ready, 0);
    check("arst_req_valid", imem_req_valid, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    modelClear();
    for (int i = 0; i < 5; i++) begin
      memRsp(rv, rd);
      cycle(0, 0, 1, rv, rd, 1, 0);
      check("arst_stray_rsp", obsInstValid, 0);
    end

    // Randomized traffic against the reference model.
    doReset();
    memJit = 3;
    pc = 0;
    for (int i = 0; i < 3000; i++) begin
      bit rr, ir, fl;
      memRsp(rv, rd);
      pv = ($urandom % 5) != 0;
      rr = ($urandom % 4) != 0;
      ir = ($urandom % 10) < 7;
      fl = ($urandom % 25) == 0;
      cycle(pv, pc, rr, rv, rd, ir, fl);
      if (fl) pc = 64'($urandom & 32'h0000_FFF0);
      else if (lastFire) pc += 4;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
